reaction_ctrl: RTL and testbench
================================

# reaction_ctrl

Sequencer for the reaction-timer datapath. Turns the single start/stop button `ss` into a complete trial:
- a pseudo-random 1–3000 ms arming delay;
- the `go` LED;
- millisecond reaction counting;
- a one-cycle `capture` strobe for the display latch.

It also flags early presses (cheat) and no-response timeouts, and optionally tracks the best time. It sits between the debounced button input and the display/latch datapath.

## Interface
- `TICK_DIV`, 50000 — clk cycles per 1 ms tick (≥2)
- `MAX_RT`, 9999 — reaction count at which the trial times out (≤16382)
- `clk` in 1 — system clock, all logic on rising edge
- `reset` in 1 — synchronous, active-low; one clock; reset is synchronous and active-low
- `ss` in 1 — start/stop button, already synchronized and debounced; the block uses rising edges only
- `go` out 1 — LED, high only in state GO
- `capture` out 1 — one-cycle latch strobe on a valid stop press
- `rt_ms` out 14 — last result in ms
- `cheat` out 1 — press occurred during the arming delay
- `timeout` out 1 — no press before `MAX_RT`
- `busy` out 1 — high in WAIT and GO
- `best_ms` out 14 — best valid time (see Configuration)

## Operation
- **Edge detect:** `ss_q` is a register. `edge = ss & ~ss_q`. `ss_q` resets to 0.
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, reset value 16'hACE1. It advances every clock in every state.
- **Delay computation:** `r = lfsr[11:0]`. If `r ≥ 3000` then `r -= 3000`. `D = r + 1`, giving a range of 1..3000. The LFSR value is sampled in the edge cycle.
- **Prescaler:** counts 0..`TICK_DIV`-1, and `tick` is high when it equals `TICK_DIV`-1. It is cleared on entry to WAIT and on entry to GO.
- **IDLE:** on `edge`, go to WAIT, load `D`, clear `cheat` and `timeout`.
- **WAIT:** `tick` decrements `D`. When `tick` and `D==1`, go to GO and clear the reaction counter `rc`. On `edge`, go to DONE with `cheat=1` and `rt_ms=0`.
- **GO:** `tick` increments `rc`.
  - On `edge`: go to DONE, `rt_ms=rc`, pulse `capture`.
  - When `tick` and `rc==MAX_RT-1`: go to DONE, `rt_ms=MAX_RT`, `timeout=1`, no `capture`.
- **DONE:** holds all results. On `edge`, go to IDLE; `rt_ms` is kept and the flags are held until the next WAIT entry.
- **Simultaneous events:**
  - `edge` with the final WAIT tick → cheat wins.
  - `edge` with a GO tick → the stop wins and `rc` is not incremented.
  - `edge` with the timeout tick → the stop wins, `rt_ms=rc` (value `MAX_RT`-1), `capture` pulses.
- **Illegal state encoding:** → IDLE next cycle.

## Timing
- **Reset values:** state IDLE, `go=0`, `capture=0`, `cheat=0`, `timeout=0`, `busy=0`, `rt_ms=0`, `rc=0`, `D=0`, `prescaler=0`.
  - `best_ms`: 14'h3FFF with `BEST_TIME_EN`, otherwise 0.
- **Reset mid-trial:** any state returns to IDLE on the next edge, with all of the above applied.
- **Moore outputs:** `go` and `busy` decode the state register. `go` is high from the first GO cycle, and low in the first DONE cycle.
- **Registered strobe:** `capture` and the new `rt_ms` appear together in the first DONE cycle, one clock after the `edge` cycle. `capture` is exactly one cycle wide.
- **WAIT duration:** exactly `D*TICK_DIV` cycles.
- **Reaction count:** `rt_ms` = number of ticks in GO before the stop edge. Ticks fall in GO cycles `TICK_DIV`, 2·`TICK_DIV`, …
- **Latency:** `edge` in IDLE → `busy` high the next cycle.
- **`ss` held high across reset release:** produces no edge.

## Configuration
- **`REACTION_BEST_TIME_EN` defined:** `best_ms` is a register, reset to 14'h3FFF (meaning "none"). It loads `rt_ms` in the `capture` cycle when the new value is less than `best_ms`. Cheat and timeout never update it.
- **`REACTION_BEST_TIME_EN` undefined:** no register; `best_ms` is tied to 0.
- All other behaviour is identical either way.

## Test plan
- **Reset:** drive `reset=0` for 2 cycles → all outputs at their reset values; `best_ms`=16383 with EN, 0 without; no edge even with `ss=1`.
- **Normal trial** (`TICK_DIV`=4): press; after `go` rises, put the stop edge in the 26th GO cycle → next cycle `capture`=1 for one cycle, `rt_ms`=6, `go`=0, `busy`=0. With EN, `best_ms`=6.
- **Cheat:** press, then press again 5 cycles into WAIT → DONE, `cheat`=1, `rt_ms`=0, `capture` never high, `go` never high, `best_ms` unchanged.
- **Timeout** (`TICK_DIV`=4, `MAX_RT`=10): no stop press → DONE after 40 GO cycles, `timeout`=1, `rt_ms`=10, no `capture`.
- **Delay model:** run 200 trials against a bench LFSR model → each WAIT length equals `D*4`, with `D` in 1..3000 and matching the model.
- **Simultaneous events and mid-trial reset:** stop edge on a GO tick cycle → `rt_ms` excludes that tick. Reset asserted while `go`=1 → IDLE with reset values next cycle.

Source files
------------

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-timer sequencer (random arming delay, go LED, ms count, capture strobe).
// Define REACTION_BEST_TIME_EN to keep a best-time register on best_ms; otherwise best_ms is 0.
module reaction_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int MAX_RT   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ss,
    output logic        go,
    output logic        capture,
    output logic [13:0] rt_ms,
    output logic        cheat,
    output logic        timeout,
    output logic        busy,
    output logic [13:0] best_ms
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, WAIT, GO, DONE} state_t;

    state_t        state, nstate;
    logic          ss_q, ss_edge, tick;
    logic          ld_wait, ld_go, stop, cheat_ev, tout_ev;
    logic [15:0]   lfsr;
    logic [11:0]   dly, delay_val;
    logic [PW-1:0] presc;
    logic [13:0]   rc;

    assign ss_edge   = ss & ~ss_q;
    assign tick      = presc == PW'(TICK_DIV - 1);
    assign delay_val = (lfsr[11:0] >= 12'd3000 ? lfsr[11:0] - 12'd3000 : lfsr[11:0]) + 12'd1;
    assign go        = state == GO;
    assign busy      = state == WAIT || state == GO;

    always_ff @(posedge clk)
        if (!reset) state <= IDLE;
        else        state <= nstate;

    always_comb begin
        nstate   = state;
        ld_wait  = 1'b0;
        ld_go    = 1'b0;
        stop     = 1'b0;
        cheat_ev = 1'b0;
        tout_ev  = 1'b0;
        case (state)
            IDLE: if (ss_edge) begin
                nstate  = WAIT;
                ld_wait = 1'b1;
            end
            WAIT: if (ss_edge) begin
                nstate   = DONE;
                cheat_ev = 1'b1;
            end else if (tick && dly == 12'd1) begin
                nstate = GO;
                ld_go  = 1'b1;
            end
            GO: if (ss_edge) begin
                nstate = DONE;
                stop   = 1'b1;
            end else if (tick && rc == 14'(MAX_RT - 1)) begin
                nstate  = DONE;
                tout_ev = 1'b1;
            end
            DONE: if (ss_edge) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // ss_q follows ss even in reset so a button held across release is not a press
    always_ff @(posedge clk) begin
        ss_q <= ss;
        if (!reset) begin
            lfsr    <= 16'hACE1;
            presc   <= '0;
            dly     <= '0;
            rc      <= '0;
            rt_ms   <= '0;
            capture <= 1'b0;
            cheat   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            presc   <= (ld_wait || ld_go || tick) ? '0 : presc + 1'b1;
            capture <= stop;
            if (ld_wait)                   dly <= delay_val;
            else if (state == WAIT && tick) dly <= dly - 12'd1;
            if (ld_go)                                 rc <= '0;
            else if (state == GO && tick && !ss_edge)  rc <= rc + 14'd1;
            if (ld_wait) begin
                cheat   <= 1'b0;
                timeout <= 1'b0;
            end
            if (cheat_ev) begin
                cheat <= 1'b1;
                rt_ms <= '0;
            end
            if (stop) rt_ms <= rc;
            if (tout_ev) begin
                timeout <= 1'b1;
                rt_ms   <= 14'(MAX_RT);
            end
        end
    end

`ifdef REACTION_BEST_TIME_EN
    always_ff @(posedge clk)
        if (!reset)                          best_ms <= 14'h3FFF;
        else if (capture && rt_ms < best_ms) best_ms <= rt_ms;
`else
    assign best_ms = '0;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: vector table, randomized trials against an LFSR/arithmetic model, reset corners.
module tb_reaction_ctrl;
    localparam int TD = 4;
    localparam int MR = 10;
`ifdef REACTION_BEST_TIME_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0, ss = 1'b0;
    logic        go, capture, cheat, timeout, busy;
    logic [13:0] rt_ms, best_ms;

    int n_cmp = 0, n_bad = 0, cyc = 0, best_m;
    logic [15:0] seq [0:131071];

    typedef struct {
        int mode;
        int k;
        int dlo;
        int dhi;
        int exp_rt;
        int exp_cap;
        int exp_cheat;
        int exp_to;
    } vec_t;
    vec_t vecs [9];

    reaction_ctrl #(.TICK_DIV(TD), .MAX_RT(MR)) dut (
        .clk(clk), .reset(reset), .ss(ss), .go(go), .capture(capture), .rt_ms(rt_ms),
        .cheat(cheat), .timeout(timeout), .busy(busy), .best_ms(best_ms)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset;
        chk("rst_go", go, 0);
        chk("rst_capture", capture, 0);
        chk("rst_rt_ms", rt_ms, 0);
        chk("rst_cheat", cheat, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_best_ms", best_ms, BEST_EN ? 16383 : 0);
    endtask

    // waits for a cycle whose model LFSR gives a delay in [lo,hi] (br: 1 = raw>=3000 branch, 0 = other, -1 = any)
    task automatic find_press(input int lo, input int hi, input int br, output int d);
        int  raw;
        bit  ok;
        ok = 1'b0;
        d  = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            step;
            raw = int'(seq[cyc][11:0]);
            d   = raw >= 3000 ? raw - 2999 : raw + 1;
            ok  = d >= lo && d <= hi && (br < 0 || br == int'(raw >= 3000));
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL press_search: no delay in %0d..%0d found", lo, hi);
        end
    endtask

    task automatic run_trial(input int mode, input int k, input int dlo, input int dhi, input int br,
                             input int exp_rt, input int exp_cap, input int exp_cheat, input int exp_to);
        int d, n, g;
        bit saw_cap, saw_go;
        find_press(dlo, dhi, br, d);
        ss = 1'b1;
        step;
        ss = 1'b0;
        chk("busy_after_press", busy, 1);
        chk("go_in_wait", go, 0);
        chk("flags_cleared", {cheat, timeout}, 0);
        saw_cap = 1'b0;
        saw_go  = 1'b0;
        if (mode == 1) begin
            repeat (((k == 0) ? d * TD : k) - 1) begin
                step;
                saw_go  |= go;
                saw_cap |= capture;
            end
            ss = 1'b1;
            step;
            ss = 1'b0;
            chk("cheat_go_never", saw_go, 0);
        end else begin
            n = 1;
            while (!go && n <= d * TD + 2) begin
                step;
                saw_cap |= capture;
                if (!go) n++;
            end
            chk("wait_len", n, d * TD);
            g = 1;
            while (go && (k == 0 || g < k) && g < 200) begin
                step;
                saw_cap |= capture;
                if (go) g++;
            end
            if (k > 0 && go) begin
                ss = 1'b1;
                step;
                ss = 1'b0;
            end
            if (exp_to) chk("go_len_timeout", g, MR * TD);
        end
        chk("early_capture", saw_cap, 0);
        chk("done_capture", capture, exp_cap);
        chk("done_rt_ms", rt_ms, exp_rt);
        chk("done_cheat", cheat, exp_cheat);
        chk("done_timeout", timeout, exp_to);
        chk("done_go", go, 0);
        chk("done_busy", busy, 0);
        step;
        chk("capture_width", capture, 0);
        if (BEST_EN && exp_cap && exp_rt < best_m) best_m = exp_rt;
        chk("best_ms", best_ms, best_m);
        ss = 1'b1;
        step;
        ss = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_rt_held", rt_ms, exp_rt);
        chk("idle_flags_held", {cheat, timeout}, {exp_cheat[0], exp_to[0]});
    endtask

    initial begin
        int d, k, to, md;
        seq[0] = 16'hACE1;
        for (int i = 1; i < 131072; i++) seq[i] = lfsr_next(seq[i-1]);
        best_m = BEST_EN ? 16383 : 0;
        vecs[0] = '{0, 26, 1, 40, 6, 1, 0, 0};
        vecs[1] = '{1, 5, 2, 40, 0, 0, 1, 0};
        vecs[2] = '{0, 0, 1, 40, 10, 0, 0, 1};
        vecs[3] = '{0, 4, 1, 40, 0, 1, 0, 0};
        vecs[4] = '{0, 8, 1, 40, 1, 1, 0, 0};
        vecs[5] = '{0, 40, 1, 40, 9, 1, 0, 0};
        vecs[6] = '{0, 1, 1, 40, 0, 1, 0, 0};
        vecs[7] = '{1, 0, 1, 40, 0, 0, 1, 0};
        vecs[8] = '{0, 5, 1, 40, 1, 1, 0, 0};

        // reset with the button held: no press may be seen on release
        reset = 1'b0;
        ss    = 1'b1;
        step;
        step;
        check_reset;
        reset = 1'b1;
        repeat (3) step;
        chk("held_ss_no_edge", busy, 0);
        ss = 1'b0;

        foreach (vecs[i])
            run_trial(vecs[i].mode, vecs[i].k, vecs[i].dlo, vecs[i].dhi, -1,
                      vecs[i].exp_rt, vecs[i].exp_cap, vecs[i].exp_cheat, vecs[i].exp_to);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 5)) step;
            md = (i % 5 == 4) ? 1 : 0;
            if (md == 1) begin
                k = $urandom_range(1, 8);
                run_trial(1, k, 2, 120, i % 2, 0, 0, 1, 0);
            end else begin
                k  = $urandom_range(0, 44);
                to = (k == 0 || k > MR * TD) ? 1 : 0;
                run_trial(0, k, 1, 120, i % 2, to ? MR : (k - 1) / TD, 1 - to, 0, to);
            end
        end
        run_trial(0, 26, 1, 3000, -1, 6, 1, 0, 0);

        // reset while go is lit
        find_press(1, 40, -1, d);
        ss = 1'b1;
        step;
        ss = 1'b0;
        for (int i = 0; i < 200 && !go; i++) step;
        chk("go_before_reset", go, 1);
        repeat (3) step;
        reset = 1'b0;
        step;
        reset = 1'b1;
        check_reset;
        best_m = BEST_EN ? 16383 : 0;
        run_trial(0, 9, 1, 40, -1, 2, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
